ahbl_splitter_n: RTL and testbench
==================================

Name: ahbl_splitter_n

Overview:
- Parametrised AHB-Lite slave splitter/decoder for the peripheral sub-bus.
- Fans one AHB-Lite slave port out to NS slaves, selected by a configurable HADDR bit field.
- Registers the data-phase owner and muxes HREADY/HRESP/HRDATA back.
- Adds three things the fixed splitter lacks: a built-in default slave that returns a two-cycle ERROR for unmapped addresses, a per-slave data-phase timeout watchdog, and sticky hung-slave isolation.

Parameters:
- NS, 4: number of downstream slaves (1..16).
- DEC_MSB, 27: MSB of the HADDR decode field.
- DEC_LSB, 24: LSB of the decode field. DW = DEC_MSB-DEC_LSB+1.
- SLOT_IDS, {4'h3,4'h2,4'h1,4'h0}: NS*DW packed IDs. Slot k occupies bits [k*DW +: DW].
- TIMEOUT, 256: number of consecutive wait cycles before the watchdog fires. 0 disables the watchdog.
- BAD_DATA, 32'hBADDBEEF: HRDATA value whenever no slave owns the data phase.

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  reset, synchronous, active-high
- HSEL  in  1  splitter selected by the upstream decoder
- HADDR  in  32  address
- HTRANS  in  2  transfer type
- HREADY  out  1  muxed ready. Also serves as the sub-bus HREADY to all slaves.
- HRESP  out  1  muxed response (1 = ERROR)
- HRDATA  out  32  muxed read data
- S_HSEL  out  NS  per-slave select
- S_HRDATA  in  NS*32  slave k read data at [k*32 +: 32]
- S_HREADYOUT  in  NS  per-slave ready
- S_HRESP  in  NS  per-slave response
- HUNG  out  NS  sticky flag: slave timed out
- TO_EVT  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Decode (combinational):
  - match[k] = (HADDR[DEC_MSB:DEC_LSB] == SLOT_IDS[k]).
  - With duplicate IDs, the lowest k wins (one-hot).
  - S_HSEL[k] = HSEL & match[k] & ~HUNG[k].
- Address-phase accept: acc = HSEL & HTRANS[1] & HREADY. Sampled at the rising HCLK edge.
- FSM states: IDLE, FWD, ERR1, ERR2. A register own[log2 NS] holds the data-phase owner.
- Output per state:
  - IDLE: HREADY=1, HRESP=0, HRDATA=BAD_DATA.
  - FWD: HREADY=S_HREADYOUT[own], HRESP=S_HRESP[own], HRDATA=S_HRDATA slice own.
  - ERR1: HREADY=0, HRESP=1, HRDATA=BAD_DATA.
  - ERR2: HREADY=1, HRESP=1, HRDATA=BAD_DATA.
- Next state, evaluated whenever HREADY=1 (states IDLE, ERR2, or FWD with slave ready):
  - acc with a mapped, non-hung slave k → FWD, own<=k.
  - acc with an unmapped address or a hung target → ERR1.
  - Otherwise (no accept, or IDLE/BUSY transfer) → IDLE.
- ERR1 → ERR2 unconditionally. This is the standard two-cycle AHB error.
- Watchdog:
  - Counter wcnt is cleared on every HREADY=1 cycle.
  - In FWD it increments each cycle that S_HREADYOUT[own]=0.
  - When wcnt reaches TIMEOUT-1 in a wait cycle:
    - next state = ERR1;
    - HUNG[own]<=1;
    - TO_EVT=1 for exactly that cycle (registered, asserted the following cycle).
  - Once HUNG[k] is set, slave k never sees S_HSEL again, and all accesses to it error.
  - HUNG is cleared only by HRESET.
- Zero-latency rule: forwarding adds no wait states. Splitter-generated errors cost exactly 2 data-phase cycles.
- Reset (HRESET=1 at posedge):
  - state=IDLE, own=0, wcnt=0, HUNG=0, TO_EVT=0.
  - Outputs immediately reflect IDLE: HREADY=1, HRESP=0, HRDATA=BAD_DATA.
  - Reset asserted mid-transfer or mid-error abandons it silently.
- Simultaneous events: the watchdog firing in the same cycle the slave raises HREADYOUT cannot occur, because firing requires HREADYOUT=0. If HREADYOUT rises at wcnt=TIMEOUT-2, the transfer completes normally.
- HSEL=0 with HTRANS nonzero: no accept, no slave selected, state goes to IDLE.
- TIMEOUT=0: the watchdog logic is tied off, HUNG stays 0, TO_EVT stays 0.

Test Plan:
- NS=4, read HADDR=0x0200_0010 with slave 2 giving HRDATA=0x1234_5678 after 2 wait states → S_HSEL=4'b0100 during the address phase, HREADY low 2 cycles, HRDATA=0x1234_5678, HRESP=0.
- Read HADDR=0x0700_0000 (unmapped) → no S_HSEL; HREADY=0/HRESP=1 then HREADY=1/HRESP=1; HRDATA=0xBADDBEEF.
- TIMEOUT=8, slave 1 holds HREADYOUT=0 → after 8 wait cycles: ERR1, TO_EVT pulse, HUNG=4'b0010. A later access to 0x0100_0000 gives S_HSEL=0 and an ERROR response.
- Back-to-back pipelined transfers (slave 0, slave 3, unmapped, slave 0), all ready → own switches each cycle with zero added wait; only the unmapped transfer costs 2 cycles.
- HRESET asserted during ERR1 and during an FWD wait → next cycle HREADY=1, HRESP=0, HUNG cleared, TO_EVT=0.
- Duplicate SLOT_IDS (slots 1 and 2 = 4'h1) → only S_HSEL[1] asserts for 0x0100_0000.

Source files
------------

// File: rtl/ahbl_splitter_n_if.sv
// AHB-Lite splitter bus bundle: upstream slave port plus the fanned-out sub-bus.
interface ahbl_splitter_n_if #(
    parameter int unsigned NS = 4
);
    logic               HSEL;
    logic [31:0]        HADDR;
    logic [1:0]         HTRANS;
    logic               HREADY;
    logic               HRESP;
    logic [31:0]        HRDATA;
    logic [NS-1:0]      S_HSEL;
    logic [NS*32-1:0]   S_HRDATA;
    logic [NS-1:0]      S_HREADYOUT;
    logic [NS-1:0]      S_HRESP;
    logic [NS-1:0]      HUNG;
    logic               TO_EVT;

    modport slave (
        input  HSEL, HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
        output HREADY, HRESP, HRDATA, S_HSEL, HUNG, TO_EVT
    );

    modport master (
        output HSEL, HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
        input  HREADY, HRESP, HRDATA, S_HSEL, HUNG, TO_EVT
    );
endinterface

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite 1:NS splitter with built-in error slave, per-transfer watchdog
// and sticky isolation of slaves that stop answering.
module ahbl_splitter_n #(
    parameter int unsigned NS       = 4,
    parameter int unsigned DEC_MSB  = 27,
    parameter int unsigned DEC_LSB  = 24,
    parameter logic [NS*(DEC_MSB-DEC_LSB+1)-1:0] SLOT_IDS = {4'h3, 4'h2, 4'h1, 4'h0},
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] BAD_DATA = 32'hBADDBEEF
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahbl_splitter_n_if.slave  bus
);
    localparam int unsigned DW    = DEC_MSB - DEC_LSB + 1;
    localparam int unsigned OW    = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned WW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit          WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, FWD, ERR1, ERR2} state_e;

    state_e         state_q, state_d;
    logic [OW-1:0]  own_q, own_d;
    logic [WW-1:0]  wcnt_q, wcnt_d;
    logic [NS-1:0]  hung_q, hung_d;
    logic           to_evt_q, to_evt_d;

    logic [DW-1:0]  field;
    logic [NS-1:0]  match_oh;
    logic           hit;
    logic [OW-1:0]  tgt;
    logic           acc;
    logic           slave_wait;
    logic           fire;
    logic           hready_c;
    logic           hresp_c;
    logic [31:0]    hrdata_c;
    logic           unused_bits;

    assign field       = bus.HADDR[DEC_MSB:DEC_LSB];
    assign unused_bits = ^{bus.HADDR, bus.HTRANS[0]};

    // Priority decode: scanning downwards leaves the lowest matching slot.
    always_comb begin
        match_oh = '0;
        hit      = 1'b0;
        tgt      = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (field == SLOT_IDS[k*DW +: DW]) begin
                hit = 1'b1;
                tgt = OW'(k);
            end
        end
        if (hit) match_oh[tgt] = 1'b1;
    end

    assign bus.S_HSEL = {NS{bus.HSEL}} & match_oh & ~hung_q;
    assign acc        = bus.HSEL & bus.HTRANS[1] & hready_c;

    // Data-phase response mux.
    always_comb begin
        hready_c = 1'b1;
        hresp_c  = 1'b0;
        hrdata_c = BAD_DATA;
        unique case (state_q)
            FWD: begin
                hready_c = bus.S_HREADYOUT[own_q];
                hresp_c  = bus.S_HRESP[own_q];
                hrdata_c = bus.S_HRDATA[{own_q, 5'd0} +: 32];
            end
            ERR1: begin
                hready_c = 1'b0;
                hresp_c  = 1'b1;
            end
            ERR2: hresp_c = 1'b1;
            default: ;
        endcase
    end

    assign slave_wait = (state_q == FWD) && !bus.S_HREADYOUT[own_q];
    assign fire       = WD_EN && slave_wait && (wcnt_q == WW'(TIMEOUT - 1));

    // Next-state: new data phase on every ready cycle, else error sequencing or watchdog.
    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        wcnt_d   = wcnt_q;
        hung_d   = hung_q;
        to_evt_d = 1'b0;
        if (hready_c) begin
            wcnt_d = '0;
            if (acc) begin
                if (hit && !hung_q[tgt]) begin
                    state_d = FWD;
                    own_d   = tgt;
                end else begin
                    state_d = ERR1;
                end
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == ERR1) begin
            state_d = ERR2;
        end else if (fire) begin
            state_d       = ERR1;
            hung_d[own_q] = 1'b1;
            to_evt_d      = 1'b1;
            wcnt_d        = '0;
        end else if (WD_EN && slave_wait) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            own_q    <= '0;
            wcnt_q   <= '0;
            hung_q   <= '0;
            to_evt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            wcnt_q   <= wcnt_d;
            hung_q   <= hung_d;
            to_evt_q <= to_evt_d;
        end
    end

    assign bus.HREADY = hready_c;
    assign bus.HRESP  = hresp_c;
    assign bus.HRDATA = hrdata_c;
    assign bus.HUNG   = hung_q;
    assign bus.TO_EVT = to_evt_q;
endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Bench for ahbl_splitter_n: directed test-plan steps plus random traffic
// against a transaction-level reference model.
module tb_ahbl_splitter_n;
    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [31:0] BAD = 32'hBADDBEEF;
    localparam int K_NONE = 0;
    localparam int K_FWD  = 1;
    localparam int K_ERR  = 2;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    ahbl_splitter_n_if #(.NS(NS)) bus ();
    ahbl_splitter_n_if #(.NS(NS)) bus2 ();

    ahbl_splitter_n #(.NS(NS), .TIMEOUT(TO)) u_dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus.slave)
    );
    ahbl_splitter_n #(.NS(NS), .SLOT_IDS(16'h3110), .TIMEOUT(0)) u_dup (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus2.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what the current data phase is and how long it has waited.
    int         m_kind = K_NONE;
    int         m_slv  = 0;
    int         m_left = 0;
    int         m_waits = 0;
    logic [3:0] m_hung = '0;
    logic       m_evt  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic hsel, input logic [31:0] addr, input logic [1:0] trans);
        bus.HSEL = hsel; bus.HADDR = addr; bus.HTRANS = trans;
    endtask

    task automatic set_slv(input int k, input logic rdy, input logic resp, input logic [31:0] data);
        bus.S_HREADYOUT[k] = rdy; bus.S_HRESP[k] = resp; bus.S_HRDATA[k*32 +: 32] = data;
    endtask

    // One bus cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic e_rdy, e_resp, s_hsel, s_nseq, s_rst, s_hit;
        logic [31:0] e_data;
        logic [3:0]  e_sel;
        int f;
        @(negedge HCLK);
        e_rdy = 1'b1; e_resp = 1'b0; e_data = BAD;
        if (m_kind == K_FWD) begin
            e_rdy  = bus.S_HREADYOUT[m_slv];
            e_resp = bus.S_HRESP[m_slv];
            e_data = bus.S_HRDATA[m_slv*32 +: 32];
        end else if (m_kind == K_ERR) begin
            e_rdy  = (m_left == 1);
            e_resp = 1'b1;
        end
        f = int'(bus.HADDR[27:24]);
        s_hit = (f < NS);
        e_sel = '0;
        if (bus.HSEL && s_hit) begin
            if (!m_hung[f]) e_sel[f] = 1'b1;
        end
        chk("HREADY", 32'(bus.HREADY), 32'(e_rdy));
        chk("HRESP",  32'(bus.HRESP),  32'(e_resp));
        chk("HRDATA", bus.HRDATA, e_data);
        chk("S_HSEL", 32'(bus.S_HSEL), 32'(e_sel));
        chk("HUNG",   32'(bus.HUNG),   32'(m_hung));
        chk("TO_EVT", 32'(bus.TO_EVT), 32'(m_evt));
        s_hsel = bus.HSEL; s_nseq = bus.HTRANS[1]; s_rst = HRESET;
        @(posedge HCLK);
        if (s_rst) begin
            m_kind = K_NONE; m_waits = 0; m_hung = '0; m_evt = 1'b0;
        end else begin
            m_evt = 1'b0;
            if (e_rdy) begin
                m_waits = 0;
                if (s_hsel && s_nseq) begin
                    if (s_hit && !m_hung[f]) begin m_kind = K_FWD; m_slv = f; end
                    else begin m_kind = K_ERR; m_left = 2; end
                end else begin
                    m_kind = K_NONE;
                end
            end else if (m_kind == K_ERR) begin
                m_left = 1;
            end else begin
                m_waits++;
                if (m_waits == TO) begin
                    m_hung[m_slv] = 1'b1; m_evt = 1'b1;
                    m_kind = K_ERR; m_left = 2; m_waits = 0;
                end
            end
        end
        #1;
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(9, 0) < 8, {4'h0, 4'($urandom_range(7, 0)), 24'($urandom)},
                  2'($urandom_range(3, 0)));
            for (int k = 0; k < NS; k++)
                set_slv(k, $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, $urandom);
            tick();
        end
    endtask

    initial begin
        int waits;
        drive(1'b0, 32'h0, 2'b00);
        for (int k = 0; k < NS; k++) set_slv(k, 1'b1, 1'b0, 32'h1000_0000 + 32'(k));
        bus2.HSEL = 1'b0; bus2.HADDR = '0; bus2.HTRANS = 2'b00;
        bus2.S_HREADYOUT = '1; bus2.S_HRESP = '0; bus2.S_HRDATA = '0;
        @(posedge HCLK); #1;
        tick(); tick();
        HRESET = 1'b0;
        tick();

        // Read slave 2 with two wait states.
        drive(1'b1, 32'h0200_0010, 2'b10);
        set_slv(2, 1'b1, 1'b0, 32'h1234_5678);
        #1 chk("t1_sel", 32'(bus.S_HSEL), 32'h4);
        tick();
        drive(1'b0, 32'h0, 2'b00);
        set_slv(2, 1'b0, 1'b0, 32'h1234_5678);
        tick(); tick();
        set_slv(2, 1'b1, 1'b0, 32'h1234_5678);
        #1 chk("t1_data", bus.HRDATA, 32'h1234_5678);
        chk("t1_rdy", 32'(bus.HREADY), 32'h1);
        tick();

        // Unmapped read: two-cycle error.
        drive(1'b1, 32'h0700_0000, 2'b10);
        #1 chk("t2_sel", 32'(bus.S_HSEL), 32'h0);
        tick();
        drive(1'b0, 32'h0, 2'b00);
        #1 chk("t2_err1", {30'h0, bus.HREADY, bus.HRESP}, 32'h1);
        chk("t2_data", bus.HRDATA, BAD);
        tick();
        chk("t2_err2", {30'h0, bus.HREADY, bus.HRESP}, 32'h3);
        tick();

        // Pipelined: slave 0, slave 3, unmapped, slave 0 (held through ERR1).
        drive(1'b1, 32'h0000_0000, 2'b10); tick();
        drive(1'b1, 32'h0300_0004, 2'b10); tick();
        drive(1'b1, 32'h0700_0000, 2'b10); tick();
        drive(1'b1, 32'h0000_0008, 2'b10); tick(); tick();
        drive(1'b0, 32'h0, 2'b00); tick(); tick();

        random_traffic(400);
        drive(1'b0, 32'h0, 2'b00);
        for (int k = 0; k < NS; k++) set_slv(k, 1'b1, 1'b0, 32'h0);
        tick(); tick(); tick();
        HRESET = 1'b1; tick(); HRESET = 1'b0; tick();

        // Slave 1 hangs: watchdog after TO wait cycles.
        drive(1'b1, 32'h0100_0000, 2'b10); tick();
        drive(1'b0, 32'h0, 2'b00);
        set_slv(1, 1'b0, 1'b0, 32'h0);
        waits = 0;
        while (bus.TO_EVT !== 1'b1 && waits < 20) begin tick(); waits++; end
        chk("t3_waits", 32'(waits), 32'(TO));
        chk("t3_hung", 32'(bus.HUNG), 32'h2);
        chk("t3_err1", {30'h0, bus.HREADY, bus.HRESP}, 32'h1);
        tick();
        chk("t3_evt_clr", 32'(bus.TO_EVT), 32'h0);
        tick();
        drive(1'b1, 32'h0100_0000, 2'b10);
        #1 chk("t3_iso_sel", 32'(bus.S_HSEL), 32'h0);
        tick();
        drive(1'b0, 32'h0, 2'b00);
        #1 chk("t3_iso_err", {30'h0, bus.HREADY, bus.HRESP}, 32'h1);
        tick(); tick();

        random_traffic(300);

        // Reset during ERR1 and during a forwarded wait.
        drive(1'b0, 32'h0, 2'b00);
        for (int k = 0; k < NS; k++) set_slv(k, 1'b1, 1'b0, 32'h0);
        tick(); tick(); tick();
        drive(1'b1, 32'h0900_0000, 2'b10); tick();
        drive(1'b0, 32'h0, 2'b00);
        HRESET = 1'b1; tick(); HRESET = 1'b0;
        chk("t5a_resp", {30'h0, bus.HREADY, bus.HRESP}, 32'h2);
        chk("t5a_hung", 32'(bus.HUNG), 32'h0);
        chk("t5a_evt", 32'(bus.TO_EVT), 32'h0);
        tick();
        drive(1'b1, 32'h0000_0000, 2'b10); tick();
        drive(1'b0, 32'h0, 2'b00);
        set_slv(0, 1'b0, 1'b0, 32'h0); tick();
        HRESET = 1'b1; tick(); HRESET = 1'b0;
        chk("t5b_resp", {30'h0, bus.HREADY, bus.HRESP}, 32'h2);
        chk("t5b_data", bus.HRDATA, BAD);
        tick();

        // Duplicate IDs and disabled watchdog on the second instance.
        bus2.HSEL = 1'b1; bus2.HADDR = 32'h0100_0000; bus2.HTRANS = 2'b10;
        #1 chk("dup_sel1", 32'(bus2.S_HSEL), 32'h2);
        bus2.HADDR = 32'h0200_0000;
        #1 chk("dup_sel2", 32'(bus2.S_HSEL), 32'h0);
        bus2.HADDR = 32'h0000_0000;
        @(posedge HCLK); #1;
        bus2.HSEL = 1'b0; bus2.HTRANS = 2'b00; bus2.S_HREADYOUT[0] = 1'b0;
        for (int i = 0; i < 30; i++) @(posedge HCLK);
        #1 chk("dup_wait", 32'(bus2.HREADY), 32'h0);
        chk("dup_hung", 32'(bus2.HUNG), 32'h0);
        chk("dup_evt", 32'(bus2.TO_EVT), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
